// File: rtl/mux_pkg.sv
// Shared constants and helpers for the pipelined N-input mux.
// Provides mode encodings and the select-width helper.
package mux_pkg;

  localparam int MODE_SELECT = 0;
  localparam int MODE_RR     = 1;

  // select/grant width: at least one bit, even for two channels
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans req from ptr upward with wrap.
// Ports: clk, rst, req, take (transfer done), idx, found.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_IN = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_IN-1:0]             req,
  input  logic                          take,
  output logic [sel_width(NUM_IN)-1:0]  idx,
  output logic                          found
);

  localparam int SW = sel_width(NUM_IN);

  logic [SW-1:0] ptr;
  int            j;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_IN) j = j - NUM_IN;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = SW'(j);
      end
    end
  end

  // pointer moves just past the channel that was served
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (take) begin
      if (int'(idx) == NUM_IN - 1) ptr <= '0;
      else                         ptr <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_mux_n.sv
// N-input mux with one registered valid/ready output stage.
// Ports: clk, rst, in_data/in_valid/in_ready, sel, out_*, grant, sel_err.
module pipe_mux_n
  import mux_pkg::*;
#(
  parameter int WIDTH  = 26,
  parameter int NUM_IN = 2,
  parameter int MODE   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_IN*WIDTH-1:0]       in_data,
  input  logic [NUM_IN-1:0]             in_valid,
  output logic [NUM_IN-1:0]             in_ready,
  input  logic [sel_width(NUM_IN)-1:0]  sel,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [sel_width(NUM_IN)-1:0]  grant,
  output logic                          sel_err
);

  localparam int SW = sel_width(NUM_IN);

  logic              load;
  logic              en;
  logic              xfer;
  logic              sel_ok;
  logic [SW-1:0]     ch;
  logic [NUM_IN-1:0] oh;
  logic [WIDTH-1:0]  mux;

  assign load   = !out_valid || out_ready;
  assign sel_ok = (int'(sel) < NUM_IN);

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SW-1:0] aidx;
      logic          afound;
      rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (in_valid),
        .take  (xfer),
        .idx   (aidx),
        .found (afound)
      );
      assign ch = aidx;
      assign en = afound;
    end else begin : g_sel
      assign ch = sel;
      assign en = sel_ok;
    end
  endgenerate

  // one-hot ready for the chosen channel; nothing during reset
  always_comb begin
    oh = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      oh[k] = load && en && !rst && (ch == SW'(k));
    end
  end

  assign in_ready = oh;
  assign xfer     = |(in_valid & oh);

  always_comb begin
    mux = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (oh[k]) mux = mux | in_data[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      grant     <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux;
      grant     <= ch;
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (MODE == MODE_SELECT && !sel_ok) begin
      sel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_mux_n.sv
// Bench: three mux configs driven together, checked vs a model.
// A: sel N=2, B: sel N=3, C: round-robin N=4; all WIDTH=26.
module tb_pipe_mux_n;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [103:0] din;
  logic [3:0]   vin;
  logic [1:0]   sel2;
  logic         ordy;

  logic [1:0]   rdy_a;
  logic [2:0]   rdy_b;
  logic [3:0]   rdy_c;
  logic [25:0]  od [3];
  logic         ov [3];
  logic         err [3];
  logic [0:0]   ga;
  logic [1:0]   gb;
  logic [1:0]   gc;

  always #5 clk = ~clk;

  pipe_mux_n #(.WIDTH(26), .NUM_IN(2), .MODE(0)) ua (
    .clk(clk), .rst(rst),
    .in_data(din[51:0]), .in_valid(vin[1:0]),
    .in_ready(rdy_a), .sel(sel2[0:0]),
    .out_data(od[0]), .out_valid(ov[0]),
    .out_ready(ordy), .grant(ga), .sel_err(err[0])
  );

  pipe_mux_n #(.WIDTH(26), .NUM_IN(3), .MODE(0)) ub (
    .clk(clk), .rst(rst),
    .in_data(din[77:0]), .in_valid(vin[2:0]),
    .in_ready(rdy_b), .sel(sel2),
    .out_data(od[1]), .out_valid(ov[1]),
    .out_ready(ordy), .grant(gb), .sel_err(err[1])
  );

  pipe_mux_n #(.WIDTH(26), .NUM_IN(4), .MODE(1)) uc (
    .clk(clk), .rst(rst),
    .in_data(din), .in_valid(vin),
    .in_ready(rdy_c), .sel(sel2),
    .out_data(od[2]), .out_valid(ov[2]),
    .out_ready(ordy), .grant(gc), .sel_err(err[2])
  );

  int checks = 0;
  int errors = 0;

  // reference model: one entry per configuration
  int          n [3] = '{2, 3, 4};
  bit          mv [3];
  logic [25:0] mdat [3];
  int          mg [3];
  int          mp [3];
  bit          me [3];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 3; d++) begin
      mv[d] = 0; mdat[d] = '0; mg[d] = 0;
      mp[d] = 0; me[d] = 0;
    end
  endtask

  function automatic int sel_of(input int d);
    return (d == 0) ? int'(sel2[0]) : int'(sel2);
  endfunction

  // which channel may transfer this cycle, as a one-hot mask
  function automatic int exp_rdy(input int d);
    int c;
    if (rst) return 0;
    if (mv[d] && !ordy) return 0;
    if (d < 2) begin
      if (sel_of(d) < n[d]) return 1 << sel_of(d);
      return 0;
    end
    for (int i = 0; i < n[d]; i++) begin
      c = (mp[d] + i) % n[d];
      if (vin[c]) return 1 << c;
    end
    return 0;
  endfunction

  function automatic logic [31:0] obs_rdy(input int d);
    case (d)
      0:       return 32'(rdy_a);
      1:       return 32'(rdy_b);
      default: return 32'(rdy_c);
    endcase
  endfunction

  function automatic logic [31:0] obs_g(input int d);
    case (d)
      0:       return 32'(ga);
      1:       return 32'(gb);
      default: return 32'(gc);
    endcase
  endfunction

  // one clock: check readies, advance model at the edge, check outputs
  task automatic cyc();
    int r [3];
    int t;
    int g;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      r[d] = exp_rdy(d);
      chk($sformatf("ready%0d", d), obs_rdy(d), r[d]);
    end
    @(posedge clk);
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (d < 2 && sel_of(d) >= n[d]) me[d] = 1;
        t = r[d] & int'(vin);
        if (t != 0) begin
          g = 0;
          for (int i = 0; i < 4; i++)
            if (t == (1 << i)) g = i;
          mv[d]   = 1;
          mdat[d] = din[g*26 +: 26];
          mg[d]   = g;
          if (d == 2) mp[d] = (g + 1) % n[d];
        end else if (!mv[d] || ordy) begin
          mv[d] = 0;
        end
      end
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("valid%0d", d), 32'(ov[d]), 32'(mv[d]));
      chk($sformatf("data%0d", d), 32'(od[d]), 32'(mdat[d]));
      chk($sformatf("grant%0d", d), obs_g(d), mg[d]);
      chk($sformatf("selerr%0d", d), 32'(err[d]), 32'(me[d]));
    end
  endtask

  initial begin
    din  = '0;
    vin  = 4'hF;
    sel2 = 2'd0;
    ordy = 1'b1;
    reset_model();

    // held in reset: nothing ready, outputs cleared
    cyc();
    cyc();
    rst = 1'b0;

    // select mode, channel 1 with all-ones data
    sel2 = 2'd1;
    vin  = 4'b0011;
    din  = {8'($urandom), $urandom(), $urandom(), $urandom()};
    din[51:26] = 26'h3FFFFFF;
    #2;
    chk("req037_ready", 32'(rdy_a), 32'h2);
    cyc();
    chk("req037_valid", 32'(ov[0]), 32'h1);
    chk("req037_data", 32'(od[0]), 32'h3FFFFFF);
    chk("req037_grant", 32'(ga), 32'h1);

    // round robin sweep from a fresh pointer, no bubbles
    rst = 1'b1;
    #1;
    rst = 1'b0;
    reset_model();
    vin = 4'hF;
    for (int i = 0; i < 5; i++) begin
      din = {8'($urandom), $urandom(), $urandom(), $urandom()};
      cyc();
      chk("req039_grant", 32'(gc), 32'(i % 4));
      chk("req039_valid", 32'(ov[2]), 32'h1);
    end

    // downstream stall for three cycles
    ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = {8'($urandom), $urandom(), $urandom(), $urandom()};
      #2;
      chk("req040_ready", 32'(rdy_c), 32'h0);
      cyc();
      chk("req040_grant", 32'(gc), 32'h0);
      chk("req040_valid", 32'(ov[2]), 32'h1);
    end
    ordy = 1'b1;

    // only channel 2 valid: ptr 1 -> 3, then wrap back to 2
    vin = 4'b0100;
    cyc();
    chk("req041_g_a", 32'(gc), 32'h2);
    cyc();
    chk("req041_wrap", 32'(gc), 32'h2);
    vin = 4'hF;
    cyc();
    chk("req041_ptr3", 32'(gc), 32'h3);

    // illegal select on the three-channel instance
    sel2 = 2'd3;
    #2;
    chk("req038_ready", 32'(rdy_b), 32'h0);
    cyc();
    chk("req038_err", 32'(err[1]), 32'h1);
    chk("req038_valid", 32'(ov[1]), 32'h0);
    sel2 = 2'd0;
    cyc();
    chk("req038_sticky", 32'(err[1]), 32'h1);

    // randomized traffic
    rst = 1'b1;
    #1;
    rst = 1'b0;
    reset_model();
    for (int i = 0; i < 300; i++) begin
      din  = {8'($urandom), $urandom(), $urandom(), $urandom()};
      vin  = 4'($urandom);
      sel2 = ($urandom_range(0, 9) == 0) ? 2'd3
                                         : 2'($urandom_range(0, 2));
      ordy = ($urandom_range(0, 3) != 0);
      cyc();
    end

    // reset between edges while holding words
    vin  = 4'hF;
    sel2 = 2'd1;
    ordy = 1'b0;
    cyc();
    cyc();
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("req042_valid", 32'(ov[d]), 32'h0);
      chk("req042_data", 32'(od[d]), 32'h0);
    end
    chk("req042_err", 32'(err[1]), 32'h0);
    reset_model();
    rst  = 1'b0;
    ordy = 1'b1;
    cyc();
    chk("req034_first", 32'(ov[2]), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
